// File: rtl/noc_inject_ctrl_if.sv
// Injection-port bundle between a synthetic traffic scheduler and a router w_* port.
// The master drives the packet; the router (slave) returns ready.
interface noc_inject_ctrl_if #(
    parameter int W = 38
) ();
    logic         o_valid;
    logic [W-1:0] o_data;
    logic         i_ready;

    modport master (output o_valid, output o_data, input i_ready);
    modport slave  (input o_valid, input o_data, output i_ready);
endinterface

// File: rtl/noc_inject_ctrl.sv
// Per-PE injection scheduler: launches numPackets packets to LFSR-chosen destinations
// (never itself) at a minimum spacing of rate cycles, counting sends and stalls.
module noc_inject_ctrl #(
    parameter int          X          = 8,
    parameter int          Y          = 8,
    parameter int          x_size     = $clog2(X),
    parameter int          y_size     = $clog2(Y),
    parameter int          data_width = 32,
    parameter int          numPackets = 100,
    parameter int          rate       = 1,
    parameter int          MY_X       = 0,
    parameter int          MY_Y       = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              enable,
    noc_inject_ctrl_if.master pkt,
    output logic              busy,
    output logic              done,
    output logic [31:0]       sentCount,
    output logic [31:0]       stallCount
);
    localparam int                    PKT_W    = x_size + y_size + data_width;
    localparam logic [31:0]           NUM_PKTS = 32'(numPackets);
    localparam logic [31:0]           RATE     = 32'(rate);
    localparam logic [x_size-1:0]     MY_XV    = x_size'(MY_X);
    localparam logic [y_size-1:0]     MY_YV    = y_size'(MY_Y);
    localparam logic [data_width-17:0] SRC_ID  = (data_width - 16)'(MY_Y * X + MY_X);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state, state_next;
    logic [15:0]       lfsr, lfsr_next;
    logic [15:0]       seq, load_seq;
    logic [31:0]       gap, gap_inc, gap_next;
    logic              do_load;
    logic              handshake;
    logic              last_pkt;
    logic [x_size-1:0] raw_x, dst_x;
    logic [y_size-1:0] dst_y;
    logic [PKT_W-1:0]  next_pkt;

    assign handshake = pkt.o_valid & pkt.i_ready;
    assign last_pkt  = (sentCount + 32'd1) == NUM_PKTS;
    assign gap_inc   = (gap >= RATE) ? RATE : gap + 32'd1;

    // A packet's destination comes from the current LFSR value; the LFSR steps as it loads.
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign raw_x     = lfsr[x_size-1:0];
    assign dst_y     = lfsr[x_size+y_size-1:x_size];
    assign dst_x     = (raw_x == MY_XV && dst_y == MY_YV) ? raw_x + x_size'(1) : raw_x;
    assign load_seq  = (state == S_IDLE) ? 16'd0 : seq;
    assign next_pkt  = {SRC_ID, load_seq, dst_y, dst_x};

    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_next = state;
        gap_next   = gap;
        do_load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (NUM_PKTS == 32'd0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_SEND;
                        do_load    = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (handshake) begin
                    if (last_pkt) begin
                        state_next = S_DONE;
                    end else if (RATE == 32'd1 && enable) begin
                        do_load = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        gap_next   = 32'd1;
                    end
                end
            end
            S_WAIT: begin
                gap_next = gap_inc;
                // Compare the post-increment gap so handshakes land exactly rate cycles apart.
                if (gap_inc >= RATE && enable) begin
                    state_next = S_SEND;
                    do_load    = 1'b1;
                end
            end
            default: begin
                if (!start) state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            gap         <= 32'd0;
            lfsr        <= LFSR_SEED;
            seq         <= 16'd0;
            pkt.o_valid <= 1'b0;
            pkt.o_data  <= '0;
            sentCount   <= 32'd0;
            stallCount  <= 32'd0;
        end else begin
            state       <= state_next;
            gap         <= gap_next;
            pkt.o_valid <= (state_next == S_SEND);
            if (do_load) begin
                pkt.o_data <= next_pkt;
                lfsr       <= lfsr_next;
                seq        <= load_seq + 16'd1;
            end
            if (state == S_IDLE && start) begin
                sentCount  <= 32'd0;
                stallCount <= 32'd0;
            end else begin
                if (handshake) sentCount <= sentCount + 32'd1;
                if (pkt.o_valid && !pkt.i_ready && stallCount != 32'hFFFF_FFFF)
                    stallCount <= stallCount + 32'd1;
            end
        end
    end

    assign busy = (state == S_SEND) || (state == S_WAIT);
    assign done = (state == S_DONE);
endmodule

// File: tb/tb_noc_inject_ctrl.sv
// Self-checking bench: four scheduler instances with different parameters, checked against
// an arithmetic packet model, handshake timing rules and counter expectations.
module tb_noc_inject_ctrl;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int total = 0;
    int bad   = 0;

    // Instance A: 8x8, (0,0), 4 packets, back-to-back
    logic a_start, a_en, a_busy, a_done;
    logic [31:0] a_sent, a_stall;
    noc_inject_ctrl_if #(.W(38)) a_if ();
    noc_inject_ctrl #(.X(8), .Y(8), .numPackets(4), .rate(1), .MY_X(0), .MY_Y(0)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .enable(a_en), .pkt(a_if.master),
        .busy(a_busy), .done(a_done), .sentCount(a_sent), .stallCount(a_stall));

    // Instance B: 8x8, (5,6), 5 packets, rate 3
    logic b_start, b_en, b_busy, b_done;
    logic [31:0] b_sent, b_stall;
    noc_inject_ctrl_if #(.W(38)) b_if ();
    noc_inject_ctrl #(.X(8), .Y(8), .numPackets(5), .rate(3), .MY_X(5), .MY_Y(6)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .enable(b_en), .pkt(b_if.master),
        .busy(b_busy), .done(b_done), .sentCount(b_sent), .stallCount(b_stall));

    // Instance C: 4x4, (2,3), 1000 packets, random ready/enable
    logic c_start, c_en, c_busy, c_done;
    logic [31:0] c_sent, c_stall;
    noc_inject_ctrl_if #(.W(36)) c_if ();
    noc_inject_ctrl #(.X(4), .Y(4), .numPackets(1000), .rate(1), .MY_X(2), .MY_Y(3)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .enable(c_en), .pkt(c_if.master),
        .busy(c_busy), .done(c_done), .sentCount(c_sent), .stallCount(c_stall));

    // Instance D: zero-packet run
    logic d_start, d_en, d_busy, d_done;
    logic [31:0] d_sent, d_stall;
    noc_inject_ctrl_if #(.W(38)) d_if ();
    noc_inject_ctrl #(.X(8), .Y(8), .numPackets(0), .rate(1)) u_d (
        .clk(clk), .rst(rst), .start(d_start), .enable(d_en), .pkt(d_if.master),
        .busy(d_busy), .done(d_done), .sentCount(d_sent), .stallCount(d_stall));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int v, fb;
        v  = int'(s);
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'(((v << 1) | fb) & 16'hFFFF);
    endfunction

    // Packet value = (payload * X*Y) + dst_y*X + dst_x, payload = src_id*2^16 + seq.
    function automatic longint exp_pkt(input int nx, input int ny, input int mx, input int my,
                                       input logic [15:0] l, input int sq);
        int dx, dy;
        longint payload;
        dx = int'(l) % nx;
        dy = (int'(l) / nx) % ny;
        if (dx == mx && dy == my) dx = (dx + 1) % nx;
        payload = longint'(my * nx + mx) * 65536 + longint'(sq % 65536);
        return payload * (nx * ny) + longint'(dy * nx + dx);
    endfunction

    logic [15:0] a_lfsr, b_lfsr, c_lfsr;
    int a_seq, b_seq, c_seq;
    int hs_q[$];
    int cyc, done_cyc, model_sent, model_stall;
    logic exp_valid;

    initial begin
        rst = 1'b1;
        {a_start, b_start, c_start, d_start} = '0;
        {a_en, b_en, c_en, d_en} = '1;
        a_if.i_ready = 1'b0; b_if.i_ready = 1'b0; c_if.i_ready = 1'b0; d_if.i_ready = 1'b0;
        a_lfsr = SEED; b_lfsr = SEED; c_lfsr = SEED;
        a_seq = 0; b_seq = 0; c_seq = 0;

        repeat (3) @(negedge clk);
        check("rst_valid", a_if.o_valid, 0);
        check("rst_data", a_if.o_data, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_sent", a_sent, 0);
        check("rst_stall", a_stall, 0);
        rst = 1'b0;

        // Idle with ready high and no start: nothing moves.
        a_if.i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_valid", a_if.o_valid, 0);
            check("idle_busy", a_busy, 0);
            check("idle_done", a_done, 0);
            check("idle_sent", a_sent, 0);
        end

        // Back-to-back: four packets on consecutive cycles.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("b2b_valid", a_if.o_valid, 1);
            check("b2b_busy", a_busy, 1);
            check("b2b_data", a_if.o_data, exp_pkt(8, 8, 0, 0, a_lfsr, a_seq));
            a_lfsr = lfsr_step(a_lfsr); a_seq++;
            @(negedge clk);
        end
        check("b2b_done", a_done, 1);
        check("b2b_valid_end", a_if.o_valid, 0);
        check("b2b_sent", a_sent, 4);
        check("b2b_stall", a_stall, 0);
        @(negedge clk);
        check("b2b_back_idle", a_done, 0);

        // Restart with 5 cycles of backpressure on the first packet.
        a_if.i_ready = 1'b0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_seq = 0;
        check("restart_sent_clr", a_sent, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", a_if.o_valid, 1);
            check("bp_data_hold", a_if.o_data, exp_pkt(8, 8, 0, 0, a_lfsr, a_seq));
            @(negedge clk);
        end
        check("bp_stall5", a_stall, 5);
        check("bp_sent0", a_sent, 0);
        a_if.i_ready = 1'b1;
        a_lfsr = lfsr_step(a_lfsr); a_seq++;
        @(negedge clk);
        check("bp_first_ready_hs", a_sent, 1);
        for (int k = 1; k < 4; k++) begin
            check("restart_data", a_if.o_data, exp_pkt(8, 8, 0, 0, a_lfsr, a_seq));
            a_lfsr = lfsr_step(a_lfsr); a_seq++;
            @(negedge clk);
        end
        check("restart_done", a_done, 1);
        check("restart_sent", a_sent, 4);
        check("restart_stall", a_stall, 5);
        @(negedge clk);

        // Reset while a packet is presented: outputs drop without a clock edge.
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        check("pre_rst_valid", a_if.o_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", a_if.o_valid, 0);
        check("async_rst_data", a_if.o_data, 0);
        check("async_rst_busy", a_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        a_lfsr = SEED; a_seq = 0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle_valid", a_if.o_valid, 0);
            check("post_rst_idle_busy", a_busy, 0);
        end

        // Rate 3: handshakes exactly three cycles apart.
        b_if.i_ready = 1'b1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        cyc = 0;
        done_cyc = -1;
        while (cyc < 200 && done_cyc < 0) begin
            if (b_done) done_cyc = cyc;
            else begin
                if (b_if.o_valid) begin
                    check("rate_data", b_if.o_data, exp_pkt(8, 8, 5, 6, b_lfsr, b_seq));
                    b_lfsr = lfsr_step(b_lfsr); b_seq++;
                    hs_q.push_back(cyc);
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("rate_done_seen", b_done, 1);
        check("rate_hs_count", hs_q.size(), 5);
        if (hs_q.size() > 0) begin
            check("rate_first_hs", hs_q[0], 0);
            for (int i = 1; i < hs_q.size(); i++) check("rate_gap", hs_q[i] - hs_q[i-1], 3);
            check("rate_done_timing", done_cyc, hs_q[hs_q.size()-1] + 1);
        end
        check("rate_sent", b_sent, 5);
        @(negedge clk);

        // Random ready/enable on a 4x4 mesh with self-avoidance.
        c_start = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        exp_valid = 1'b1;
        model_sent = 0;
        model_stall = 0;
        cyc = 0;
        while (!c_done && cyc < 20000) begin
            check("rnd_valid", c_if.o_valid, exp_valid);
            c_if.i_ready = ($urandom_range(0, 3) != 0);
            c_en = ($urandom_range(0, 4) != 0);
            if (c_if.o_valid) begin
                check("rnd_data", c_if.o_data, exp_pkt(4, 4, 2, 3, c_lfsr, c_seq));
                if (c_if.i_ready) begin
                    check("rnd_not_self", (c_if.o_data[1:0] == 2'd2) && (c_if.o_data[3:2] == 2'd3), 0);
                    check("rnd_src_id", c_if.o_data[35:20], 14);
                    c_lfsr = lfsr_step(c_lfsr); c_seq++;
                    model_sent++;
                    exp_valid = (model_sent != 1000) && c_en;
                end else begin
                    model_stall++;
                    exp_valid = 1'b1;
                end
            end else begin
                exp_valid = c_en;
            end
            @(negedge clk);
            cyc++;
        end
        check("rnd_done", c_done, 1);
        check("rnd_sent", c_sent, 1000);
        check("rnd_stall", c_stall, model_stall);
        check("rnd_valid_end", c_if.o_valid, 0);
        c_if.i_ready = 1'b0;

        // Zero-packet run: done one cycle after start, no packet.
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        check("zero_done", d_done, 1);
        check("zero_valid", d_if.o_valid, 0);
        check("zero_busy", d_busy, 0);
        check("zero_sent", d_sent, 0);
        @(negedge clk);
        check("zero_back_idle", d_done, 0);
        check("zero_valid_idle", d_if.o_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
